// File: rtl/fwd_pkg.sv
// fwd_pkg: shared forwarding-select encodings and load-use FSM state type.
package fwd_pkg;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_HOLD  = 2'b11;

    typedef enum logic {RUN, LDSTALL} state_t;

endpackage

// File: rtl/fwd_src_lane.sv
// fwd_src_lane: one EX source-operand lane: producer match, forwarding priority mux,
// and a hold register that keeps a writeback landing while the pipeline is frozen.
module fwd_src_lane
    import fwd_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             valid,
    input  logic             used,
    input  logic [REG_W-1:0] addr,
    input  logic [XLEN-1:0]  value,
    input  logic             ex_mem_valid,
    input  logic             ex_mem_regwrite,
    input  logic             ex_mem_memread,
    input  logic [REG_W-1:0] ex_mem_rd_addr,
    input  logic [XLEN-1:0]  ex_mem_rd_value,
    input  logic             mem_wb_valid,
    input  logic             mem_wb_regwrite,
    input  logic [REG_W-1:0] mem_wb_rd_addr,
    input  logic [XLEN-1:0]  wb_value,
    output logic [XLEN-1:0]  operand,
    output logic [1:0]       sel,
    output logic             hazard
);

    logic            gate;
    logic            exm;
    logic            wbm;
    logic            hold_valid;
    logic [XLEN-1:0] hold_val;

    // x0 is hardwired zero, so it never matches a producer
    assign gate   = valid && used && (addr != '0);
    assign exm    = gate && ex_mem_valid && ex_mem_regwrite && (ex_mem_rd_addr == addr);
    assign wbm    = gate && mem_wb_valid && mem_wb_regwrite && (mem_wb_rd_addr == addr);
    assign hazard = exm && ex_mem_memread;

    // stall is already low during flush, so this also covers the flush clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_val   <= '0;
            hold_valid <= 1'b0;
        end else if (!stall) begin
            hold_valid <= 1'b0;
        end else if (wbm) begin
            hold_val   <= wb_value;
            hold_valid <= 1'b1;
        end
    end

    always_comb begin
        sel     = (exm && !ex_mem_memread) ? FWD_EXMEM :
                  wbm                      ? FWD_MEMWB :
                  hold_valid               ? FWD_HOLD  : FWD_IDEX;
        operand = (sel == FWD_EXMEM) ? ex_mem_rd_value :
                  (sel == FWD_MEMWB) ? wb_value        :
                  (sel == FWD_HOLD)  ? hold_val        : value;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand forwarding across NUM_SRC lanes plus the
// load-use stall FSM that freezes IF/ID, ID/EX and bubbles EX/MEM.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NUM_SRC  = 2,
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     id_ex_valid,
    input  logic [NUM_SRC-1:0]       id_ex_rs_used,
    input  logic [NUM_SRC*REG_W-1:0] id_ex_rs_addr,
    input  logic [NUM_SRC*XLEN-1:0]  id_ex_rs_value,
    input  logic                     ex_mem_valid,
    input  logic                     ex_mem_regwrite,
    input  logic                     ex_mem_memread,
    input  logic [REG_W-1:0]         ex_mem_rd_addr,
    input  logic [XLEN-1:0]          ex_mem_rd_value,
    input  logic                     mem_wb_valid,
    input  logic                     mem_wb_regwrite,
    input  logic [REG_W-1:0]         mem_wb_rd_addr,
    input  logic [XLEN-1:0]          wb_value,
    output logic [NUM_SRC*XLEN-1:0]  operand_out,
    output logic [NUM_SRC*2-1:0]     fwd_sel,
    output logic                     stall_out
);

    localparam int CW = $clog2(LOAD_LAT + 1);

    state_t               state;
    state_t               state_nx;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nx;
    logic [NUM_SRC-1:0]   lane_hazard;
    logic                 hazard;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        fwd_src_lane #(
            .XLEN (XLEN),
            .REG_W(REG_W)
        ) u_lane (
            .clk            (clk),
            .rst_n          (rst_n),
            .stall          (stall_out),
            .valid          (id_ex_valid),
            .used           (id_ex_rs_used[i]),
            .addr           (id_ex_rs_addr[i*REG_W +: REG_W]),
            .value          (id_ex_rs_value[i*XLEN +: XLEN]),
            .ex_mem_valid   (ex_mem_valid),
            .ex_mem_regwrite(ex_mem_regwrite),
            .ex_mem_memread (ex_mem_memread),
            .ex_mem_rd_addr (ex_mem_rd_addr),
            .ex_mem_rd_value(ex_mem_rd_value),
            .mem_wb_valid   (mem_wb_valid),
            .mem_wb_regwrite(mem_wb_regwrite),
            .mem_wb_rd_addr (mem_wb_rd_addr),
            .wb_value       (wb_value),
            .operand        (operand_out[i*XLEN +: XLEN]),
            .sel            (fwd_sel[i*2 +: 2]),
            .hazard         (lane_hazard[i])
        );
    end

    assign hazard = |lane_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // the first stall cycle is spent in RUN, so LDSTALL covers the remaining LOAD_LAT-1
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (flush) begin
            state_nx = RUN;
            cnt_nx   = '0;
        end else if (state == LDSTALL) begin
            cnt_nx = cnt - CW'(1);
            if (cnt == CW'(1))
                state_nx = RUN;
        end else if (hazard && LOAD_LAT > 1) begin
            state_nx = LDSTALL;
            cnt_nx   = CW'(LOAD_LAT - 1);
        end
    end

    always_comb begin
        stall_out = rst_n && !flush && ((state == LDSTALL) || hazard);
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: drives three units (LOAD_LAT 1, 3, 4) from shared stimulus and
// checks them against directed constants and a remaining-stall-count reference model.
module tb_fwd_hazard_unit;

    localparam int XL = 64;
    localparam int NS = 2;
    localparam int RW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              v;
    logic [NS-1:0]     used;
    logic [NS*RW-1:0]  addr;
    logic [NS*XL-1:0]  rsval;
    logic              xm_v, xm_rw, xm_mr;
    logic [RW-1:0]     xm_rd;
    logic [XL-1:0]     xm_val;
    logic              mw_v, mw_rw;
    logic [RW-1:0]     mw_rd;
    logic [XL-1:0]     wbv;

    logic [NS*XL-1:0]  op_o [3];
    logic [NS*2-1:0]   sel_o [3];
    logic              stall_o [3];

    int pass = 0;
    int total = 0;

    int          rem [3];
    bit          hv [3][NS];
    logic [XL-1:0] hval [3][NS];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fwd_hazard_unit #(
            .XLEN    (XL),
            .NUM_SRC (NS),
            .REG_W   (RW),
            .LOAD_LAT(g == 0 ? 1 : (g == 1 ? 3 : 4))
        ) dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .flush          (flush),
            .id_ex_valid    (v),
            .id_ex_rs_used  (used),
            .id_ex_rs_addr  (addr),
            .id_ex_rs_value (rsval),
            .ex_mem_valid   (xm_v),
            .ex_mem_regwrite(xm_rw),
            .ex_mem_memread (xm_mr),
            .ex_mem_rd_addr (xm_rd),
            .ex_mem_rd_value(xm_val),
            .mem_wb_valid   (mw_v),
            .mem_wb_regwrite(mw_rw),
            .mem_wb_rd_addr (mw_rd),
            .wb_value       (wbv),
            .operand_out    (op_o[g]),
            .fwd_sel        (sel_o[g]),
            .stall_out      (stall_o[g])
        );
    end

    function automatic int lat(int k);
        return k == 0 ? 1 : (k == 1 ? 3 : 4);
    endfunction

    function automatic logic [RW-1:0] ra(int i);
        return addr[i*RW +: RW];
    endfunction

    function automatic bit em(int i);
        return v && used[i] && ra(i) != 0 && xm_v && xm_rw && xm_rd == ra(i);
    endfunction

    function automatic bit wm(int i);
        return v && used[i] && ra(i) != 0 && mw_v && mw_rw && mw_rd == ra(i);
    endfunction

    function automatic bit hazard_m();
        for (int i = 0; i < NS; i++)
            if (em(i) && xm_mr) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] m_sel(int k, int i);
        if (em(i) && !xm_mr) return 2'b10;
        if (wm(i)) return 2'b01;
        if (hv[k][i]) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [XL-1:0] m_op(int k, int i);
        case (m_sel(k, i))
            2'b10:   return xm_val;
            2'b01:   return wbv;
            2'b11:   return hval[k][i];
            default: return rsval[i*XL +: XL];
        endcase
    endfunction

    function automatic bit m_stall(int k);
        return rst_n && !flush && (rem[k] > 0 || hazard_m());
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            rem[k] = 0;
            for (int i = 0; i < NS; i++) begin
                hv[k][i] = 1'b0;
                hval[k][i] = '0;
            end
        end
    endtask

    // samples the model's view of the cycle, then advances it across one clock edge
    task automatic tick();
        bit st [3];
        bit w [NS];
        logic [XL-1:0] wv;
        bit fl;
        bit rn;
        for (int k = 0; k < 3; k++) st[k] = m_stall(k);
        for (int i = 0; i < NS; i++) w[i] = wm(i);
        wv = wbv;
        fl = flush;
        rn = rst_n;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rn || fl) rem[k] = 0;
            else if (rem[k] > 0) rem[k]--;
            else if (st[k]) rem[k] = lat(k) - 1;
            for (int i = 0; i < NS; i++) begin
                if (!st[k]) hv[k][i] = 1'b0;
                else if (w[i]) begin
                    hv[k][i] = 1'b1;
                    hval[k][i] = wv;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        flush = 0; v = 0; used = '0; addr = '0;
        xm_v = 0; xm_rw = 0; xm_mr = 0; xm_rd = '0; xm_val = '0;
        mw_v = 0; mw_rw = 0; mw_rd = '0; wbv = '0;
        rsval = {64'h2222, 64'h11};
    endtask

    task automatic idle_ticks(int n);
        idle();
        for (int j = 0; j < n; j++) tick();
    endtask

    // consumer of x7 in lane 0, load of x7 sitting in EX/MEM
    task automatic load_hazard();
        v = 1; used = 2'b01; addr = {5'd3, 5'd7};
        xm_v = 1; xm_rw = 1; xm_mr = 1; xm_rd = 5'd7; xm_val = 64'hDEAD;
        mw_v = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        model_reset();
        v = 1; used = 2'b11; addr = {5'd2, 5'd1};
        #1;
        for (int k = 0; k < 3; k++) begin
            total++; if (stall_o[k] !== 1'b0) $display("FAIL rst_stall[%0d] got %b want 0", k, stall_o[k]); else pass++;
            total++; if (sel_o[k] !== 4'b0000) $display("FAIL rst_sel[%0d] got %b want 0000", k, sel_o[k]); else pass++;
            total++; if (op_o[k] !== rsval) $display("FAIL rst_op[%0d] got %h want %h", k, op_o[k], rsval); else pass++;
        end
        tick();
        tick();
        rst_n = 1;
        idle_ticks(2);
    endtask

    task automatic test_exmem_forward();
        idle();
        v = 1; used = 2'b01; addr = {5'd3, 5'd5};
        xm_v = 1; xm_rw = 1; xm_mr = 0; xm_rd = 5'd5; xm_val = 64'hAA;
        mw_v = 1; mw_rw = 1; mw_rd = 5'd5; wbv = 64'hBB;
        #1;
        total++; if (op_o[0][63:0] !== 64'hAA) $display("FAIL exm_op got %h want aa", op_o[0][63:0]); else pass++;
        total++; if (sel_o[0][1:0] !== 2'b10) $display("FAIL exm_sel got %b want 10", sel_o[0][1:0]); else pass++;
        total++; if (stall_o[0] !== 1'b0) $display("FAIL exm_stall got %b want 0", stall_o[0]); else pass++;
        xm_rd = 5'd6;
        #1;
        total++; if (op_o[0][63:0] !== 64'hBB) $display("FAIL wbm_op got %h want bb", op_o[0][63:0]); else pass++;
        total++; if (sel_o[0][1:0] !== 2'b01) $display("FAIL wbm_sel got %b want 01", sel_o[0][1:0]); else pass++;
        used = 2'b00;
        #1;
        total++; if (sel_o[0][1:0] !== 2'b00) $display("FAIL unused_sel got %b want 00", sel_o[0][1:0]); else pass++;
        total++; if (op_o[0][63:0] !== 64'h11) $display("FAIL unused_op got %h want 11", op_o[0][63:0]); else pass++;
        idle();
    endtask

    task automatic test_x0();
        idle();
        v = 1; used = 2'b11; addr = '0;
        rsval = {64'h22, 64'h11};
        xm_v = 1; xm_rw = 1; xm_mr = 1; xm_rd = '0; xm_val = 64'hAA;
        mw_v = 1; mw_rw = 1; mw_rd = '0; wbv = 64'hBB;
        #1;
        total++; if (op_o[0][127:64] !== 64'h22) $display("FAIL x0_op1 got %h want 22", op_o[0][127:64]); else pass++;
        total++; if (sel_o[0] !== 4'b0000) $display("FAIL x0_sel got %b want 0000", sel_o[0]); else pass++;
        for (int k = 0; k < 3; k++) begin
            total++; if (stall_o[k] !== 1'b0) $display("FAIL x0_stall[%0d] got %b want 0", k, stall_o[k]); else pass++;
        end
        idle();
    endtask

    task automatic test_load_use();
        idle();
        load_hazard();
        #1;
        total++; if (stall_o[0] !== 1'b1) $display("FAIL lu_stall got %b want 1", stall_o[0]); else pass++;
        total++; if (sel_o[0][1:0] !== 2'b00) $display("FAIL lu_sel_stall got %b want 00", sel_o[0][1:0]); else pass++;
        tick();
        xm_v = 0;
        mw_v = 1; mw_rw = 1; mw_rd = 5'd7; wbv = 64'h1234;
        #1;
        total++; if (stall_o[0] !== 1'b0) $display("FAIL lu_release got %b want 0", stall_o[0]); else pass++;
        total++; if (op_o[0][63:0] !== 64'h1234) $display("FAIL lu_op got %h want 1234", op_o[0][63:0]); else pass++;
        total++; if (sel_o[0][1:0] !== 2'b01) $display("FAIL lu_sel got %b want 01", sel_o[0][1:0]); else pass++;
        tick();
        idle_ticks(6);
    endtask

    task automatic test_hold();
        idle();
        load_hazard();
        #1;
        total++; if (stall_o[1] !== 1'b1) $display("FAIL hold_stall1 got %b want 1", stall_o[1]); else pass++;
        tick();
        xm_v = 0;
        mw_v = 1; mw_rw = 1; mw_rd = 5'd7; wbv = 64'h55;
        #1;
        total++; if (stall_o[1] !== 1'b1) $display("FAIL hold_stall2 got %b want 1", stall_o[1]); else pass++;
        total++; if (sel_o[1][1:0] !== 2'b01) $display("FAIL hold_sel2 got %b want 01", sel_o[1][1:0]); else pass++;
        tick();
        mw_v = 0; wbv = 64'h0;
        #1;
        total++; if (stall_o[1] !== 1'b1) $display("FAIL hold_stall3 got %b want 1", stall_o[1]); else pass++;
        total++; if (sel_o[1][1:0] !== 2'b11) $display("FAIL hold_sel3 got %b want 11", sel_o[1][1:0]); else pass++;
        tick();
        total++; if (stall_o[1] !== 1'b0) $display("FAIL hold_release got %b want 0", stall_o[1]); else pass++;
        total++; if (op_o[1][63:0] !== 64'h55) $display("FAIL hold_op got %h want 55", op_o[1][63:0]); else pass++;
        total++; if (sel_o[1][1:0] !== 2'b11) $display("FAIL hold_sel got %b want 11", sel_o[1][1:0]); else pass++;
        tick();
        total++; if (sel_o[1][1:0] !== 2'b00) $display("FAIL hold_clear_sel got %b want 00", sel_o[1][1:0]); else pass++;
        total++; if (op_o[1][63:0] !== 64'h11) $display("FAIL hold_clear_op got %h want 11", op_o[1][63:0]); else pass++;
        idle_ticks(6);
    endtask

    task automatic test_reset_mid_stall();
        idle();
        load_hazard();
        tick();
        xm_v = 0;
        mw_v = 1; mw_rw = 1; mw_rd = 5'd7; wbv = 64'h77;
        #1;
        total++; if (stall_o[2] !== 1'b1) $display("FAIL rmid_stall got %b want 1", stall_o[2]); else pass++;
        tick();
        mw_v = 0;
        #1;
        total++; if (sel_o[2][1:0] !== 2'b11) $display("FAIL rmid_hold_sel got %b want 11", sel_o[2][1:0]); else pass++;
        #2;
        rst_n = 0;
        model_reset();
        xm_v = 1;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++; if (stall_o[k] !== 1'b0) $display("FAIL rmid_drop[%0d] got %b want 0", k, stall_o[k]); else pass++;
        end
        total++; if (sel_o[2][1:0] !== 2'b00) $display("FAIL rmid_sel got %b want 00", sel_o[2][1:0]); else pass++;
        tick();
        rst_n = 1;
        xm_v = 0;
        #1;
        total++; if (stall_o[2] !== 1'b0) $display("FAIL rmid_run got %b want 0", stall_o[2]); else pass++;
        total++; if (op_o[2][63:0] !== 64'h11) $display("FAIL rmid_op got %h want 11", op_o[2][63:0]); else pass++;
        idle_ticks(2);
    endtask

    task automatic test_flush();
        idle();
        load_hazard();
        tick();
        xm_v = 0;
        flush = 1;
        mw_v = 1; mw_rw = 1; mw_rd = 5'd7; wbv = 64'h99;
        #1;
        total++; if (stall_o[1] !== 1'b0) $display("FAIL fl_stall1 got %b want 0", stall_o[1]); else pass++;
        total++; if (stall_o[2] !== 1'b0) $display("FAIL fl_stall2 got %b want 0", stall_o[2]); else pass++;
        total++; if (sel_o[1][1:0] !== 2'b01) $display("FAIL fl_sel got %b want 01", sel_o[1][1:0]); else pass++;
        tick();
        flush = 0;
        mw_v = 0;
        #1;
        total++; if (stall_o[1] !== 1'b0) $display("FAIL fl_run1 got %b want 0", stall_o[1]); else pass++;
        total++; if (stall_o[2] !== 1'b0) $display("FAIL fl_run2 got %b want 0", stall_o[2]); else pass++;
        total++; if (sel_o[2][1:0] !== 2'b00) $display("FAIL fl_hold_sel got %b want 00", sel_o[2][1:0]); else pass++;
        total++; if (op_o[2][63:0] !== 64'h11) $display("FAIL fl_op got %h want 11", op_o[2][63:0]); else pass++;
        idle_ticks(2);
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 0;
                model_reset();
            end else begin
                rst_n = 1;
            end
            flush  = $urandom_range(0, 15) == 0;
            v      = $urandom_range(0, 7) != 0;
            used   = NS'($urandom);
            addr   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            rsval  = {$urandom, $urandom, $urandom, $urandom};
            xm_v   = $urandom_range(0, 3) != 0;
            xm_rw  = $urandom_range(0, 3) != 0;
            xm_mr  = $urandom_range(0, 2) == 0;
            xm_rd  = 5'($urandom_range(0, 3));
            xm_val = {$urandom, $urandom};
            mw_v   = $urandom_range(0, 3) != 0;
            mw_rw  = $urandom_range(0, 3) != 0;
            mw_rd  = 5'($urandom_range(0, 3));
            wbv    = {$urandom, $urandom};
            #1;
            for (int k = 0; k < 3; k++) begin
                total++; if (stall_o[k] !== m_stall(k)) $display("FAIL rnd_stall[%0d] cyc %0d got %b want %b", k, n, stall_o[k], m_stall(k)); else pass++;
                for (int i = 0; i < NS; i++) begin
                    total++; if (sel_o[k][i*2 +: 2] !== m_sel(k, i)) $display("FAIL rnd_sel[%0d][%0d] cyc %0d got %b want %b", k, i, n, sel_o[k][i*2 +: 2], m_sel(k, i)); else pass++;
                    total++; if (op_o[k][i*XL +: XL] !== m_op(k, i)) $display("FAIL rnd_op[%0d][%0d] cyc %0d got %h want %h", k, i, n, op_o[k][i*XL +: XL], m_op(k, i)); else pass++;
                end
            end
            tick();
        end
        rst_n = 1;
        idle_ticks(2);
    endtask

    initial begin
        test_reset();
        test_exmem_forward();
        test_x0();
        test_load_use();
        test_hold();
        test_reset_mid_stall();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised EX-stage operand forwarding and load-use hazard unit: it selects each ALU source operand from ID/EX, EX/MEM, MEM/WB or a local hold register, and asserts a pipeline stall while a load result is not yet forwardable. It generalises the fixed two-operand forwarding mux to NUM_SRC lanes. It adds x0 suppression, a load-use stall FSM with configurable bubble count, and hold registers that catch a writeback landing during a stall. It sits between the ID/EX register and the ALU; stall_out drives the IF/ID and ID/EX freeze and the EX/MEM bubble insert.

## Interface
- XLEN, 64: operand width
- NUM_SRC, 2: number of source-operand lanes
- REG_W, 5: register address width
- LOAD_LAT, 1: stall cycles per load-use hazard (>=1)
- clk  in  1  pipeline clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- flush  in  1  synchronous pipeline flush
- id_ex_valid  in  1  EX-stage instruction valid
- id_ex_rs_used  in  NUM_SRC  per-lane "source is read" mask
- id_ex_rs_addr  in  NUM_SRC*REG_W  lane i at [i*REG_W +: REG_W]
- id_ex_rs_value  in  NUM_SRC*XLEN  register-file values latched in ID/EX
- ex_mem_valid, ex_mem_regwrite, ex_mem_memread  in  1 each  MEM-stage producer qualifiers
- ex_mem_rd_addr  in  REG_W; ex_mem_rd_value  in  XLEN
- mem_wb_valid, mem_wb_regwrite  in  1 each; mem_wb_rd_addr  in  REG_W
- wb_value  in  XLEN  writeback-mux output
- operand_out  out  NUM_SRC*XLEN  selected operands
- fwd_sel  out  NUM_SRC*2  per-lane source select (debug/trace)
- stall_out  out  1  freeze upstream, bubble EX/MEM

## Operation
- Lane i match terms, all gated by id_ex_valid & rs_used[i] & rs_addr[i]!=0:
  - exm_i = ex_mem_valid & ex_mem_regwrite & ex_mem_rd_addr==rs_addr[i]
  - wbm_i = mem_wb_valid & mem_wb_regwrite & mem_wb_rd_addr==rs_addr[i]
- Select priority per lane: exm_i & !ex_mem_memread -> EX/MEM (10); else wbm_i -> MEM/WB (01); else hold_valid[i] -> HOLD (11); else ID/EX (00).
- rs_addr==0 always selects ID/EX, never forwards, never stalls.
- hazard = OR over lanes of (exm_i & ex_mem_memread).
- FSM RUN / LDSTALL, counter cnt of width $clog2(LOAD_LAT+1):
  - RUN: hazard -> stall_out=1. If LOAD_LAT==1, stay RUN. Else go LDSTALL with cnt=LOAD_LAT-1.
  - LDSTALL: stall_out=1, cnt decrements each cycle; cnt==1 -> RUN next edge.
  - stall_out = (RUN & hazard) | LDSTALL.
- Hold registers, one per lane (hold_val XLEN, hold_valid 1):
  - On any edge with stall_out=1 and wbm_i, capture wb_value and set hold_valid[i].
  - Clear all hold_valid on the first edge with stall_out=0, when ID/EX advances.
- flush: FSM -> RUN, cnt=0, all hold_valid cleared on the next edge; overrides capture. stall_out is 0 in the flush cycle.
- Simultaneous new hazard on the cycle stall releases: re-enters stall via RUN & hazard. The clear still occurs only when stall_out=0.

## Timing
- operand_out, fwd_sel, stall_out are combinational from inputs and state: zero-cycle latency.
- State (FSM, cnt, hold) updates on posedge clk.
- Reset (rst_n low, async): FSM=RUN, cnt=0, hold_val=0, hold_valid=0. While rst_n low, stall_out is forced 0. operand_out and fwd_sel follow the mux with holds empty.
- Reset asserted mid-LDSTALL: stall_out drops immediately, holds discarded.
- Load-use with LOAD_LAT=N: stall_out high exactly N consecutive cycles, assuming the bubble moves the load out of EX/MEM.

## Structure
- Package fwd_pkg: FWD_IDEX=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10, FWD_HOLD=2'b11; FSM state typedef {RUN, LDSTALL}.
- Sub-module fwd_src_lane, instantiated NUM_SRC times via generate: match compare, priority mux, hold register.
- Top level owns the FSM, counter, hazard OR-reduce and flush/reset.

## Test plan
- EX/MEM ALU forward: rs1=5, ex_mem rd=5 value 0xAA, mem_wb rd=5 value 0xBB -> operand0=0xAA, fwd_sel0=10, stall_out=0.
- x0 suppression: rs2=0, ex_mem rd=0 regwrite=1 -> operand1=id_ex value, fwd_sel1=00.
- Load-use, LOAD_LAT=1: load in EX/MEM rd=7, consumer rs1=7 -> stall_out=1 for 1 cycle. Next cycle, load in MEM/WB with wb_value=0x1234 -> operand0=0x1234, fwd_sel0=01.
- LOAD_LAT=3 with hold: stall 3 cycles; wb of rd=7=0x55 in stall cycle 2, then MEM/WB empties -> after release operand0=0x55, fwd_sel0=11. hold_valid clears after first non-stall edge.
- Reset mid-LDSTALL (LOAD_LAT=4, cycle 2): rst_n low -> stall_out=0 immediately. After release, FSM=RUN and operands from ID/EX.
- flush during LDSTALL -> stall_out=0 in the flush cycle. Next edge FSM=RUN and holds cleared; a concurrent wbm capture is ignored.
